regfile_mp: RTL and testbench

- Parametrised multi-port general-purpose register file for the NPC core.
- Next generation of the single-port register store: NREAD independent registered read ports and one write port.
- x0 is hardwired to zero. PC is a dedicated register, not an array entry.
- A per-register busy scoreboard supports pipelined issue/writeback hazard checks. Sits between decode (reads, issue) and writeback (write).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 35 +++
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the multi-port register file
package regfile_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_PC   = 32'h8000_0000;
  localparam int unsigned ZERO_REG       = 0;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register write-pending bits for issue/writeback hazards
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NREG       = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_busy,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  output logic [NREG-1:0]       busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a newly issued producer to the same register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wen && (waddr != ADDR_WIDTH'(ZERO_REG))) busy_d[waddr] = 1'b0;
    if (set_busy && (set_addr != ADDR_WIDTH'(ZERO_REG))) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NREAD registered read ports, one write port, dedicated PC and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    NREAD      = 2,
  parameter int                    BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEF_RESET_PC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREAD-1:0]            ren,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  output logic [NREAD-1:0]            rbusy,
  input  logic                        wen,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        set_busy,
  input  logic [ADDR_WIDTH-1:0]       set_addr,
  input  logic                        pc_wen,
  input  logic [DATA_WIDTH-1:0]       pc_next,
  output logic [DATA_WIDTH-1:0]       pc
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]       mem_q [NREG];
  logic [DATA_WIDTH-1:0]       mem_d [NREG];
  logic [NREAD*DATA_WIDTH-1:0] rdata_q;
  logic [NREAD*DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0]       pc_q;
  logic [DATA_WIDTH-1:0]       pc_d;
  logic [NREG-1:0]             busy;
  logic [ADDR_WIDTH-1:0]       ra [NREAD];
  logic [NREAD-1:0]            fwd_hit;
  logic                        wr_ok;

  assign wr_ok = wen && (waddr != ADDR_WIDTH'(ZERO_REG));

  for (genvar g = 0; g < NREAD; g++) begin : g_port
    assign ra[g]      = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign fwd_hit[g] = (BYPASS != 0) && wen && (waddr == ra[g]);
    // A write landing this cycle only clears the hazard when it can be forwarded.
    assign rbusy[g]   = busy[ra[g]] & ~fwd_hit[g];
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[waddr] = wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    for (int i = 0; i < NREAD; i++) begin
      if (ren[i]) begin
        if (ra[i] == ADDR_WIDTH'(ZERO_REG))
          rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        else if (fwd_hit[i])
          rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = wdata;
        else
          rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra[i]];
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_wen) pc_d = pc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) mem_q[k] <= '0;
      rdata_q <= '0;
      pc_q    <= RESET_PC;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
      pc_q    <= pc_d;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NREG       (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_busy (set_busy),
    .set_addr (set_addr),
    .wen      (wen),
    .waddr    (waddr),
    .busy     (busy)
  );

  assign rdata = rdata_q;
  assign pc    = pc_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed and randomized checks of regfile_mp against a behavioural model
module tb_regfile_mp;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ren;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        wen;
  reg_addr_t   waddr;
  xlen_t       wdata;
  logic        set_busy;
  reg_addr_t   set_addr;
  logic        pc_wen;
  xlen_t       pc_next;
  xlen_t       pc;

  int checks   = 0;
  int failures = 0;

  xlen_t m_rf [32];
  bit    m_bz [32];
  xlen_t m_rd [2];
  xlen_t m_pc;

  regfile_mp #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .NREAD      (2),
    .BYPASS     (1),
    .RESET_PC   (32'h8000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ren      (ren),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .set_busy (set_busy),
    .set_addr (set_addr),
    .pc_wen   (pc_wen),
    .pc_next  (pc_next),
    .pc       (pc)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = '0;
      m_bz[i] = 1'b0;
    end
    m_rd[0] = '0;
    m_rd[1] = '0;
    m_pc    = 32'h8000_0000;
  endtask

  task automatic idle();
    ren = '0; raddr = '0; wen = 0; waddr = '0; wdata = '0;
    set_busy = 0; set_addr = '0; pc_wen = 0; pc_next = '0;
  endtask

  // One clock edge; the model applies the architectural rules to the inputs held across it.
  task automatic tick();
    xlen_t nrd [2];
    reg_addr_t a;
    for (int p = 0; p < 2; p++) begin
      a = raddr[p*5 +: 5];
      nrd[p] = m_rd[p];
      if (ren[p]) begin
        if (a == 0)                      nrd[p] = '0;
        else if (wen && waddr == a)      nrd[p] = wdata;
        else                             nrd[p] = m_rf[a];
      end
    end
    @(posedge clk);
    if (wen && waddr != 0) begin
      m_rf[waddr] = wdata;
      m_bz[waddr] = 1'b0;
    end
    if (set_busy && set_addr != 0) m_bz[set_addr] = 1'b1;
    if (pc_wen) m_pc = pc_next;
    m_rd[0] = nrd[0];
    m_rd[1] = nrd[1];
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 32'h8000_0000) begin failures++; $display("FAIL reset_pc got=%h exp=80000000", pc); end
    checks++; if (rdata !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    rst = 1'b0;
    wen = 1; waddr = 5; wdata = 32'h1234; set_busy = 1; set_addr = 6;
    pc_wen = 1; pc_next = 32'h0000_0100;
    tick();
    idle();
    ren = 2'b01; raddr[4:0] = 5;
    tick();
    checks++; if (rdata[31:0] !== 32'h1234) begin failures++; $display("FAIL pre_reset_read got=%h exp=00001234", rdata[31:0]); end
    idle();
    raddr[4:0] = 6;
    #1;
    checks++; if (rbusy[0] !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%b exp=1", rbusy[0]); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++; if (pc !== 32'h8000_0000) begin failures++; $display("FAIL async_reset_pc got=%h exp=80000000", pc); end
    checks++; if (rdata !== 64'h0) begin failures++; $display("FAIL async_reset_rdata got=%h exp=0", rdata); end
    checks++; if (rbusy !== 2'b00) begin failures++; $display("FAIL async_reset_rbusy got=%b exp=00", rbusy); end
    #2 rst = 1'b0;
    ren = 2'b01; raddr[4:0] = 5;
    tick();
    checks++; if (rdata[31:0] !== 32'h0) begin failures++; $display("FAIL post_reset_x5 got=%h exp=0", rdata[31:0]); end
    idle();
  endtask

  task automatic test_write_read();
    wen = 1; waddr = 3; wdata = 32'hDEAD_BEEF;
    tick();
    idle();
    ren = 2'b11; raddr[4:0] = 3; raddr[9:5] = 0;
    tick();
    checks++; if (rdata[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_x3 got=%h exp=deadbeef", rdata[31:0]); end
    checks++; if (rdata[63:32] !== 32'h0) begin failures++; $display("FAIL read_x0_port1 got=%h exp=0", rdata[63:32]); end
    idle();
  endtask

  task automatic test_x0();
    wen = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
    tick();
    idle();
    ren = 2'b01; raddr[4:0] = 0;
    tick();
    checks++; if (rdata[31:0] !== 32'h0) begin failures++; $display("FAIL x0_write_dropped got=%h exp=0", rdata[31:0]); end
    idle();
    set_busy = 1; set_addr = 0;
    tick();
    idle();
    #1;
    checks++; if (rbusy !== 2'b00) begin failures++; $display("FAIL x0_never_busy got=%b exp=00", rbusy); end
  endtask

  task automatic test_collision();
    wen = 1; waddr = 7; wdata = 32'h1;
    tick();
    idle();
    wen = 1; waddr = 7; wdata = 32'h2;
    ren = 2'b11; raddr[4:0] = 7; raddr[9:5] = 7;
    tick();
    checks++; if (rdata[31:0] !== 32'h2) begin failures++; $display("FAIL bypass_port0 got=%h exp=00000002", rdata[31:0]); end
    checks++; if (rdata[63:32] !== 32'h2) begin failures++; $display("FAIL bypass_port1 got=%h exp=00000002", rdata[63:32]); end
    idle();
    wen = 1; waddr = 7; wdata = 32'h3; raddr[4:0] = 7;
    tick();
    checks++; if (rdata[31:0] !== 32'h2) begin failures++; $display("FAIL hold_when_ren0 got=%h exp=00000002", rdata[31:0]); end
    idle();
  endtask

  task automatic test_scoreboard();
    set_busy = 1; set_addr = 9;
    tick();
    idle();
    raddr[9:5] = 9;
    #1;
    checks++; if (rbusy[1] !== 1'b1) begin failures++; $display("FAIL busy_after_issue got=%b exp=1", rbusy[1]); end
    set_busy = 1; set_addr = 9; wen = 1; waddr = 9; wdata = 32'h99;
    #1;
    checks++; if (rbusy[1] !== 1'b0) begin failures++; $display("FAIL busy_fwd_masked got=%b exp=0", rbusy[1]); end
    tick();
    idle();
    raddr[9:5] = 9;
    #1;
    checks++; if (rbusy[1] !== 1'b1) begin failures++; $display("FAIL set_wins_over_clear got=%b exp=1", rbusy[1]); end
    wen = 1; waddr = 9; wdata = 32'h100;
    #1;
    checks++; if (rbusy[1] !== 1'b0) begin failures++; $display("FAIL busy_comb_clear got=%b exp=0", rbusy[1]); end
    tick();
    idle();
    raddr[9:5] = 9;
    #1;
    checks++; if (rbusy[1] !== 1'b0) begin failures++; $display("FAIL busy_cleared got=%b exp=0", rbusy[1]); end
    idle();
  endtask

  task automatic test_pc();
    pc_wen = 1; pc_next = 32'h8000_0004;
    tick();
    checks++; if (pc !== 32'h8000_0004) begin failures++; $display("FAIL pc_load got=%h exp=80000004", pc); end
    for (int c = 0; c < 3; c++) begin
      pc_wen = 0; pc_next = $urandom;
      tick();
      checks++; if (pc !== 32'h8000_0004) begin failures++; $display("FAIL pc_hold cycle=%0d got=%h exp=80000004", c, pc); end
    end
    pc_wen = 1; pc_next = 32'h0000_0003;
    tick();
    checks++; if (pc !== 32'h0000_0003) begin failures++; $display("FAIL pc_unaligned got=%h exp=00000003", pc); end
    idle();
  endtask

  task automatic test_random();
    reg_addr_t a;
    bit exp_b;
    for (int n = 0; n < 400; n++) begin
      ren      = 2'($urandom);
      raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wen      = 1'($urandom_range(0, 1));
      waddr    = 5'($urandom_range(0, 7));
      wdata    = $urandom;
      set_busy = 1'($urandom_range(0, 1));
      set_addr = 5'($urandom_range(0, 7));
      pc_wen   = ($urandom_range(0, 3) == 0);
      pc_next  = $urandom;
      #1;
      for (int p = 0; p < 2; p++) begin
        a = raddr[p*5 +: 5];
        exp_b = m_bz[a] && !(wen && waddr == a);
        checks++; if (rbusy[p] !== exp_b) begin failures++; $display("FAIL rnd_rbusy n=%0d port=%0d addr=%0d got=%b exp=%b", n, p, a, rbusy[p], exp_b); end
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        checks++; if (rdata[p*32 +: 32] !== m_rd[p]) begin failures++; $display("FAIL rnd_rdata n=%0d port=%0d got=%h exp=%h", n, p, rdata[p*32 +: 32], m_rd[p]); end
      end
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc, m_pc); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_collision();
    test_scoreboard();
    test_pc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
